// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with 2-bit saturating direction counters,
// trained from MEM-stage resolution. Define BP_GSHARE_EN to index the counters by idx ^ GHR.
module branch_predictor #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_ENTRIES = 16,
    parameter int GHR_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] IF_pc,
    output logic                  IF_pred_taken,
    output logic [DATA_WIDTH-1:0] IF_pred_target,
    input  logic                  MEM_update,
    input  logic [DATA_WIDTH-1:0] MEM_pc,
    input  logic                  MEM_is_jump,
    input  logic                  MEM_taken,
    input  logic [DATA_WIDTH-1:0] MEM_target
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] jump_q;
    logic [TAG_W-1:0]       tag_q    [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  target_q [NUM_ENTRIES];
    // Per-entry counters, or the pattern history table when gshare is enabled.
    logic [1:0]             ctr_q    [NUM_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] lk_ctr_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [IDX_W-1:0] up_ctr_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_d;
    logic             btb_we;
    logic             ctr_we;
    logic             unused_pc_lsbs;

    assign lk_idx = IF_pc[IDX_W+1:2];
    assign lk_tag = IF_pc[DATA_WIDTH-1:IDX_W+2];
    assign up_idx = MEM_pc[IDX_W+1:2];
    assign up_tag = MEM_pc[DATA_WIDTH-1:IDX_W+2];
    assign unused_pc_lsbs = ^{IF_pc[1:0], MEM_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_WIDTH-1:0] ghr_q;
    logic [GHR_WIDTH-1:0] ghr_d;
    logic [IDX_W-1:0]     ghr_ext;

    assign ghr_ext    = IDX_W'(ghr_q);
    assign lk_ctr_idx = lk_idx ^ ghr_ext;
    assign up_ctr_idx = up_idx ^ ghr_ext;

    // Only conditional branches shift history; the shift uses the pre-update GHR.
    assign ghr_d = (MEM_update && !MEM_is_jump) ? ((ghr_q << 1) | GHR_WIDTH'(MEM_taken)) : ghr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign lk_ctr_idx = lk_idx;
    assign up_ctr_idx = up_idx;
`endif

    // Lookup: no bypass from a same-cycle update, the arrays are read as they stand.
    assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign IF_pred_taken  = lk_hit && (jump_q[lk_idx] || ctr_q[lk_ctr_idx][1]);
    assign IF_pred_target = IF_pred_taken ? target_q[lk_idx] : IF_pc + DATA_WIDTH'(4);

    assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign ctr_cur = ctr_q[up_ctr_idx];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        btb_we = 1'b0;
        ctr_we = 1'b0;
        ctr_d  = ctr_cur;
        if (MEM_update && (up_hit || MEM_taken)) begin
            btb_we = 1'b1;
            ctr_we = 1'b1;
            if (MEM_is_jump) begin
                ctr_d = 2'b11;
            end else if (MEM_taken) begin
                ctr_d = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
            end else begin
                ctr_d = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
            end
`ifndef BP_GSHARE_EN
            // A fresh branch allocation starts weak-taken, whatever the evicted entry held.
            if (!up_hit && !MEM_is_jump) begin
                ctr_d = 2'b10;
            end
`endif
        end
    end

    // NOTE: sequential state is written with <= only, so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            if (btb_we) begin
                valid_q[up_idx] <= 1'b1;
            end
            if (ctr_we) begin
                ctr_q[up_ctr_idx] <= ctr_d;
            end
        end
    end

    // NOTE: tag/target/jump storage is not reset; valid=0 masks stale contents,
    // letting these arrays map onto plain RAM.
    always_ff @(posedge clk) begin
        if (btb_we && !reset) begin
            tag_q[up_idx]  <= up_tag;
            jump_q[up_idx] <= MEM_is_jump;
            if (MEM_taken) begin
                target_q[up_idx] <= MEM_target;
            end
        end
    end

endmodule
